// File: rtl/sram_arbiter_if.sv
// Bus bundle between the cache/fetch ports, the arbiter and the SRAM controller.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface sram_arbiter_if;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned WDATA_W = 32;
  localparam int unsigned RDATA_W = 64;

  // data port (cache controller)
  logic [ADDR_W-1:0]  d_addr;
  logic [WDATA_W-1:0] d_wdata;
  logic               d_rd_en;
  logic               d_wr_en;
  logic [RDATA_W-1:0] d_rdata;
  logic               d_ready;

  // instruction port (read only)
  logic [ADDR_W-1:0]  i_addr;
  logic               i_rd_en;
  logic [RDATA_W-1:0] i_rdata;
  logic               i_ready;

  // SRAM controller side
  logic [ADDR_W-1:0]  sram_addr;
  logic [WDATA_W-1:0] sram_wdata;
  logic               sram_rd_en;
  logic               sram_wr_en;
  logic [RDATA_W-1:0] sram_rdata;
  logic               sram_ready;

  modport slave (
    input  d_addr, d_wdata, d_rd_en, d_wr_en, i_addr, i_rd_en, sram_rdata, sram_ready,
    output d_rdata, d_ready, i_rdata, i_ready, sram_addr, sram_wdata, sram_rd_en, sram_wr_en
  );

  modport master (
    output d_addr, d_wdata, d_rd_en, d_wr_en, i_addr, i_rd_en, sram_rdata, sram_ready,
    input  d_rdata, d_ready, i_rdata, i_ready, sram_addr, sram_wdata, sram_rd_en, sram_wr_en
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port SRAM arbiter: data port (read/write) and instruction port (read only)
// share one SRAM controller; fixed priority or round-robin selected by RR_MODE.
module sram_arbiter #(
  parameter int unsigned RR_MODE = 1
) (
  input logic           clk,
  input logic           rst,
  sram_arbiter_if.slave bus
);
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned WDATA_W = 32;
  localparam int unsigned RDATA_W = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_D = 2'd1,
    GRANT_I = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               last_i;
  logic [ADDR_W-1:0]  lat_addr;
  logic [WDATA_W-1:0] lat_wdata;
  logic               lat_wr;

  logic d_req_c;
  logic i_req_c;
  logic grant_d_c;
  logic grant_i_c;
  logic in_grant_c;
  logic d_done_c;
  logic i_done_c;

  always_comb begin
    d_req_c = bus.d_rd_en | bus.d_wr_en;
    i_req_c = bus.i_rd_en;
  end

  // Arbitration decision and next state; grants are only issued from IDLE
  always_comb begin
    state_nxt = state;
    grant_d_c = 1'b0;
    grant_i_c = 1'b0;
    case (state)
      IDLE: begin
        if (d_req_c && i_req_c) begin
          if ((RR_MODE != 0) && !last_i) grant_i_c = 1'b1;
          else                           grant_d_c = 1'b1;
        end else if (d_req_c) begin
          grant_d_c = 1'b1;
        end else if (i_req_c) begin
          grant_i_c = 1'b1;
        end
        if (grant_d_c)      state_nxt = GRANT_D;
        else if (grant_i_c) state_nxt = GRANT_I;
      end
      GRANT_D, GRANT_I: begin
        if (bus.sram_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Transaction capture on the grant edge; later requester changes cannot disturb it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_i    <= 1'b1;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wr    <= 1'b0;
    end else if (grant_d_c) begin
      last_i    <= 1'b0;
      lat_addr  <= bus.d_addr;
      lat_wdata <= bus.d_wr_en ? bus.d_wdata : '0;
      lat_wr    <= bus.d_wr_en;
    end else if (grant_i_c) begin
      last_i    <= 1'b1;
      lat_addr  <= bus.i_addr;
      lat_wdata <= '0;
      lat_wr    <= 1'b0;
    end
  end

  always_comb begin
    in_grant_c = (state == GRANT_D) || (state == GRANT_I);
    d_done_c   = (state == GRANT_D) && bus.sram_ready;
    i_done_c   = (state == GRANT_I) && bus.sram_ready;
  end

  // SRAM request is quiet outside a grant, so a stray sram_ready in IDLE is harmless
  assign bus.sram_addr  = in_grant_c ? lat_addr : '0;
  assign bus.sram_wdata = (in_grant_c && lat_wr) ? lat_wdata : '0;
  assign bus.sram_rd_en = in_grant_c && !lat_wr;
  assign bus.sram_wr_en = in_grant_c && lat_wr;

  assign bus.d_ready = !d_req_c || d_done_c;
  assign bus.i_ready = !i_req_c || i_done_c;
  assign bus.d_rdata = (d_done_c && !lat_wr) ? bus.sram_rdata : RDATA_W'(0);
  assign bus.i_rdata = (i_done_c && !lat_wr) ? bus.sram_rdata : RDATA_W'(0);
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a round-robin and a fixed-priority instance share stimulus
// and are both compared each cycle against a transaction-level reference model.
module tb_sram_arbiter;
  typedef struct packed {
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        sram_rd_en;
    logic        sram_wr_en;
    logic [63:0] d_rdata;
    logic        d_ready;
    logic [63:0] i_rdata;
    logic        i_ready;
  } outs_t;

  logic        clk;
  logic        rst;
  logic [31:0] d_addr, d_wdata, i_addr;
  logic        d_rd_en, d_wr_en, i_rd_en, sram_ready;
  logic [63:0] sram_rdata;

  int checks = 0;
  int passed = 0;

  // reference model, index 0 = fixed priority, 1 = round-robin
  bit          m_busy  [2];
  bit          m_own_i [2];
  bit          m_wr    [2];
  bit          m_last_i[2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];

  sram_arbiter_if bus_rr ();
  sram_arbiter_if bus_fp ();

  assign bus_rr.d_addr     = d_addr;
  assign bus_rr.d_wdata    = d_wdata;
  assign bus_rr.d_rd_en    = d_rd_en;
  assign bus_rr.d_wr_en    = d_wr_en;
  assign bus_rr.i_addr     = i_addr;
  assign bus_rr.i_rd_en    = i_rd_en;
  assign bus_rr.sram_rdata = sram_rdata;
  assign bus_rr.sram_ready = sram_ready;
  assign bus_fp.d_addr     = d_addr;
  assign bus_fp.d_wdata    = d_wdata;
  assign bus_fp.d_rd_en    = d_rd_en;
  assign bus_fp.d_wr_en    = d_wr_en;
  assign bus_fp.i_addr     = i_addr;
  assign bus_fp.i_rd_en    = i_rd_en;
  assign bus_fp.sram_rdata = sram_rdata;
  assign bus_fp.sram_ready = sram_ready;

  sram_arbiter #(.RR_MODE(1)) dut_rr (.clk(clk), .rst(rst), .bus(bus_rr));
  sram_arbiter #(.RR_MODE(0)) dut_fp (.clk(clk), .rst(rst), .bus(bus_fp));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t observe(input bit rr);
    outs_t o;
    if (rr) begin
      o.sram_addr = bus_rr.sram_addr;   o.sram_wdata = bus_rr.sram_wdata;
      o.sram_rd_en = bus_rr.sram_rd_en; o.sram_wr_en = bus_rr.sram_wr_en;
      o.d_rdata = bus_rr.d_rdata;       o.d_ready = bus_rr.d_ready;
      o.i_rdata = bus_rr.i_rdata;       o.i_ready = bus_rr.i_ready;
    end else begin
      o.sram_addr = bus_fp.sram_addr;   o.sram_wdata = bus_fp.sram_wdata;
      o.sram_rd_en = bus_fp.sram_rd_en; o.sram_wr_en = bus_fp.sram_wr_en;
      o.d_rdata = bus_fp.d_rdata;       o.d_ready = bus_fp.d_ready;
      o.i_rdata = bus_fp.i_rdata;       o.i_ready = bus_fp.i_ready;
    end
    return o;
  endfunction

  // Expected outputs this cycle from the model's view of the transaction in flight
  function automatic outs_t predict(input int m);
    outs_t e;
    bit    dreq;
    e    = '0;
    dreq = d_rd_en || d_wr_en;
    if (m_busy[m]) begin
      e.sram_addr  = m_addr[m];
      e.sram_wr_en = m_wr[m];
      e.sram_rd_en = !m_wr[m];
      e.sram_wdata = m_wr[m] ? m_wdata[m] : 32'h0;
    end
    e.d_ready = !dreq || (m_busy[m] && !m_own_i[m] && sram_ready);
    e.i_ready = !i_rd_en || (m_busy[m] && m_own_i[m] && sram_ready);
    if (m_busy[m] && sram_ready && !m_wr[m]) begin
      if (m_own_i[m]) e.i_rdata = sram_rdata;
      else            e.d_rdata = sram_rdata;
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_busy[m] = 0; m_own_i[m] = 0; m_wr[m] = 0; m_last_i[m] = 1;
      m_addr[m] = '0; m_wdata[m] = '0;
    end
  endtask

  // Transaction-level update applied at each rising edge
  task automatic model_edge();
    bit dreq, win_i;
    dreq = d_rd_en || d_wr_en;
    if (rst) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      if (m_busy[m]) begin
        if (sram_ready) m_busy[m] = 0;
      end else if (dreq || i_rd_en) begin
        win_i       = i_rd_en && (!dreq || (m == 1 && !m_last_i[m]));
        m_busy[m]   = 1;
        m_own_i[m]  = win_i;
        m_last_i[m] = win_i;
        m_addr[m]   = win_i ? i_addr : d_addr;
        m_wr[m]     = !win_i && d_wr_en;
        m_wdata[m]  = d_wdata;
      end
    end
  endtask

  task automatic advance();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    d_rd_en = 0; d_wr_en = 0; i_rd_en = 0; sram_ready = 0;
    d_addr = '0; d_wdata = '0; i_addr = '0; sram_rdata = '0;
  endtask

  task automatic reset_pulse();
    idle_inputs();
    rst = 1;
    model_reset();
    advance();
    rst = 0;
  endtask

  task automatic test_reset();
    outs_t o, e;
    idle_inputs();
    rst = 1;
    model_reset();
    @(negedge clk);
    #1;
    e = '0; e.d_ready = 1; e.i_ready = 1;
    for (int r = 0; r < 2; r++) begin
      o = observe(r[0]);
      checks++;
      if (o === e) passed++;
      else $display("FAIL reset_state dut%0d: got %h expected %h", r, o, e);
    end
    rst = 0;
    advance();
    #1;
    o = observe(1);
    e = predict(1);
    checks++;
    if (o === e && o.sram_rd_en === 1'b0) passed++;
    else $display("FAIL reset_release: got %h expected %h", o, e);
  endtask

  task automatic test_data_read();
    outs_t o, e;
    bit    g;
    reset_pulse();
    d_addr = 32'h100;
    for (int k = 0; k < 5; k++) begin
      d_rd_en    = (k < 4);
      sram_ready = (k == 0) || (k == 3);
      sram_rdata = (k == 3) ? 64'hAAAA_BBBB_CCCC_DDDD : 64'h5555_6666_7777_8888;
      #1;
      o = observe(1);
      e = predict(1);
      g = (k >= 1) && (k <= 3);
      checks++;
      if (o === e) passed++;
      else $display("FAIL data_read_model k=%0d: got %h expected %h", k, o, e);
      checks++;
      if (o.sram_rd_en === g && o.sram_wr_en === 1'b0 && o.sram_addr === (g ? 32'h100 : 32'h0) &&
          o.d_ready === (k >= 3) && o.d_rdata === ((k == 3) ? 64'hAAAA_BBBB_CCCC_DDDD : 64'h0) &&
          o.i_ready === 1'b1)
        passed++;
      else $display("FAIL data_read k=%0d: got %h", k, o);
      advance();
    end
  endtask

  task automatic test_data_write();
    outs_t o, e;
    bit    g;
    reset_pulse();
    d_addr = 32'h40; d_wdata = 32'h1234_5678;
    for (int k = 0; k < 4; k++) begin
      d_wr_en    = (k < 3);
      d_rd_en    = (k < 3);
      sram_ready = (k == 2);
      sram_rdata = 64'hDEAD_BEEF_0000_FFFF;
      #1;
      o = observe(1);
      e = predict(1);
      g = (k == 1) || (k == 2);
      checks++;
      if (o === e) passed++;
      else $display("FAIL data_write_model k=%0d: got %h expected %h", k, o, e);
      checks++;
      if (o.sram_wr_en === g && o.sram_rd_en === 1'b0 && o.sram_addr === (g ? 32'h40 : 32'h0) &&
          o.sram_wdata === (g ? 32'h1234_5678 : 32'h0) && o.d_ready === (k >= 2) && o.d_rdata === 64'h0)
        passed++;
      else $display("FAIL data_write k=%0d: got %h", k, o);
      advance();
    end
  endtask

  task automatic test_arbitration();
    outs_t o, e;
    int    t;
    reset_pulse();
    d_addr = 32'hD0; i_addr = 32'h10; d_rd_en = 1; i_rd_en = 1;
    for (int k = 0; k < 12; k++) begin
      t          = k / 3;
      sram_ready = (k % 3 == 2);
      sram_rdata = 64'(k) << 8;
      #1;
      for (int r = 0; r < 2; r++) begin
        o = observe(r[0]);
        e = predict(r);
        checks++;
        if (o === e) passed++;
        else $display("FAIL arb_model dut%0d k=%0d: got %h expected %h", r, k, o, e);
      end
      o = observe(1);
      checks++;
      if (o.d_ready === (k % 3 == 2 && t % 2 == 0) && o.i_ready === (k % 3 == 2 && t % 2 == 1) &&
          (k % 3 == 0 || o.sram_addr === ((t % 2 == 0) ? 32'hD0 : 32'h10)))
        passed++;
      else $display("FAIL rr_order k=%0d: addr %h d_ready %b i_ready %b", k, o.sram_addr, o.d_ready, o.i_ready);
      o = observe(0);
      checks++;
      if (o.i_ready === 1'b0 && o.d_ready === (k % 3 == 2) && (k % 3 == 0 || o.sram_addr === 32'hD0))
        passed++;
      else $display("FAIL fixed_prio k=%0d: addr %h d_ready %b i_ready %b", k, o.sram_addr, o.d_ready, o.i_ready);
      advance();
    end
    idle_inputs();
    advance();
  endtask

  task automatic test_addr_change();
    outs_t o, e;
    logic [31:0] want;
    reset_pulse();
    for (int k = 0; k < 6; k++) begin
      d_rd_en    = (k < 5);
      d_addr     = (k >= 1) ? 32'h20 : 32'h10;
      sram_ready = (k == 2) || (k == 4);
      sram_rdata = 64'h0123_4567_89AB_CDEF;
      want       = (k == 1 || k == 2) ? 32'h10 : ((k == 4) ? 32'h20 : 32'h0);
      #1;
      o = observe(1);
      e = predict(1);
      checks++;
      if (o === e) passed++;
      else $display("FAIL addr_change_model k=%0d: got %h expected %h", k, o, e);
      checks++;
      if (o.sram_addr === want && o.d_ready === (k == 2 || k >= 4)) passed++;
      else $display("FAIL addr_change k=%0d: addr %h expected %h d_ready %b", k, o.sram_addr, want, o.d_ready);
      advance();
    end
  endtask

  task automatic test_reset_mid();
    outs_t o, e;
    reset_pulse();
    i_rd_en = 1; i_addr = 32'h80;
    advance();
    #1;
    o = observe(1);
    checks++;
    if (o.sram_rd_en === 1'b1 && o.sram_addr === 32'h80 && o.i_ready === 1'b0) passed++;
    else $display("FAIL mid_grant_i: got %h", o);
    #2;
    rst = 1; sram_ready = 1; sram_rdata = 64'hFFFF_0000_FFFF_0000;
    model_reset();
    #1;
    for (int r = 0; r < 2; r++) begin
      o = observe(r[0]);
      e = '0; e.d_ready = 1;
      checks++;
      if (o === e && o === predict(r)) passed++;
      else $display("FAIL reset_mid dut%0d: got %h expected %h", r, o, e);
    end
    advance();
    rst = 0; sram_ready = 0; d_rd_en = 1; d_addr = 32'hD4;
    advance();
    #1;
    for (int r = 0; r < 2; r++) begin
      o = observe(r[0]);
      checks++;
      if (o === predict(r) && o.sram_addr === 32'hD4 && o.sram_rd_en === 1'b1 && o.i_ready === 1'b0) passed++;
      else $display("FAIL post_reset_grant dut%0d: got %h", r, o);
    end
    sram_ready = 1;
    advance();
    idle_inputs();
    advance();
  endtask

  task automatic test_random();
    outs_t o, e;
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 79) == 0);
      if (rst) model_reset();
      d_rd_en    = ($urandom_range(0, 2) != 0);
      d_wr_en    = ($urandom_range(0, 3) == 0);
      i_rd_en    = ($urandom_range(0, 2) != 0);
      d_addr     = $urandom;
      d_wdata    = $urandom;
      i_addr     = $urandom;
      sram_ready = ($urandom_range(0, 2) == 0);
      sram_rdata = {$urandom, $urandom};
      #1;
      for (int r = 0; r < 2; r++) begin
        o = observe(r[0]);
        e = predict(r);
        checks++;
        if (o === e) passed++;
        else $display("FAIL random dut%0d k=%0d: got %h expected %h", r, k, o, e);
      end
      advance();
    end
    rst = 0;
    idle_inputs();
    advance();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_data_read();
    test_data_write();
    test_arbitration();
    test_addr_change();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
